// File: rtl/alu_if.sv
// Operand/result bundle between the datapath registers and the registered ALU.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] input_A;
    logic [WIDTH-1:0] input_B;
    logic [2:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] output_S;
    logic             out_valid;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    modport master (
        output input_A, input_B, op, in_valid,
        input  output_S, out_valid, flag_c, flag_z, flag_v, flag_n
    );

    modport slave (
        input  input_A, input_B, op, in_valid,
        output output_S, out_valid, flag_c, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/alu.sv
// Registered 8-bit ALU (add/sub/logic/shift/compare) for the vending-machine datapath.
// Latency: 1 clk from an accepted in_valid to output_S/flags and a one-cycle out_valid pulse.
// Backpressure: none; every accepted in_valid yields one out_valid. Optional ALU_SATURATE_EN clamps ADD/SUB.
module alu #(
    parameter int WIDTH = 8
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    op_e              op_sel;
    logic [2:0]       amt;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic             a_msb;
    logic             b_msb;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] res_s;
    logic             res_c;
    logic             res_v;

    logic [WIDTH-1:0] s_q;
    logic             vld_q;
    logic             c_q;
    logic             z_q;
    logic             v_q;
    logic             n_q;

    assign op_sel = op_e'(bus.op);
    assign amt    = bus.input_B[2:0];
    assign a_msb  = bus.input_A[WIDTH-1];
    assign b_msb  = bus.input_B[WIDTH-1];

    // Extra top bit carries ADD carry-out and SUB borrow (A<B unsigned).
    assign sum_w  = {1'b0, bus.input_A} + {1'b0, bus.input_B};
    assign diff_w = {1'b0, bus.input_A} - {1'b0, bus.input_B};

    // Shifting through a 9-bit window leaves the last bit shifted out in the guard bit,
    // and a zero shift leaves the guard bit clear.
    assign shl_w  = {1'b0, bus.input_A} << amt;
    assign shr_w  = {bus.input_A, 1'b0} >> amt;

    assign add_ovf = (a_msb == b_msb) && (sum_w[WIDTH-1] != a_msb);
    assign sub_ovf = (a_msb != b_msb) && (diff_w[WIDTH-1] != a_msb);

    always_comb begin
        res_s = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (op_sel)
            OP_ADD: begin
                res_s = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = add_ovf;
`ifdef ALU_SATURATE_EN
                if (sum_w[WIDTH]) res_s = '1;
`endif
            end
            OP_SUB: begin
                res_s = diff_w[WIDTH-1:0];
                res_c = diff_w[WIDTH];
                res_v = sub_ovf;
`ifdef ALU_SATURATE_EN
                if (diff_w[WIDTH]) res_s = '0;
`endif
            end
            OP_AND: res_s = bus.input_A & bus.input_B;
            OP_OR:  res_s = bus.input_A | bus.input_B;
            OP_XOR: res_s = bus.input_A ^ bus.input_B;
            OP_SHL: begin
                res_s = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_s = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            OP_CMP: begin
                res_s = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
                res_c = diff_w[WIDTH];
            end
            default: begin
                res_s = '0;
                res_c = 1'b0;
                res_v = 1'b0;
            end
        endcase
    end

    // Z/N come from the value actually registered, so they follow any saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q   <= '0;
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            v_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q <= res_s;
                c_q <= res_c;
                z_q <= (res_s == '0);
                v_q <= res_v;
                n_q <= res_s[WIDTH-1];
            end
        end
    end

    assign bus.output_S  = s_q;
    assign bus.out_valid = vld_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_n    = n_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal cases, hold/async-reset, then randomized traffic vs a model.
module tb_alu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic check_en;

    logic [11:0] exp_out;
    logic        exp_vld;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed overflow is judged on true integer range, not on sign-bit rules.
    function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
        int s, c, v, r, sa, sb, sr, k;
        logic [7:0] s8;
        s = 0; c = 0; v = 0;
        k  = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin
                r  = a + b;
                c  = (r > 255) ? 1 : 0;
                sr = sa + sb;
                v  = (sr > 127 || sr < -128) ? 1 : 0;
                s  = r % 256;
`ifdef ALU_SATURATE_EN
                if (c == 1) s = 255;
`endif
            end
            1: begin
                r  = a - b;
                c  = (a < b) ? 1 : 0;
                sr = sa - sb;
                v  = (sr > 127 || sr < -128) ? 1 : 0;
                s  = (r + 256) % 256;
`ifdef ALU_SATURATE_EN
                if (c == 1) s = 0;
`endif
            end
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: begin
                s = (a * (1 << k)) % 256;
                c = (k == 0) ? 0 : (a / (1 << (8 - k))) % 2;
            end
            6: begin
                s = a / (1 << k);
                c = (k == 0) ? 0 : (a / (1 << (k - 1))) % 2;
            end
            default: begin
                s = (a < b) ? 1 : 0;
                c = s;
            end
        endcase
        s8 = s[7:0];
        return {s8, c[0], (s == 0), v[0], (s >= 128)};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got S=%02h C%b Z%b V%b N%b vld%b, want S=%02h C%b Z%b V%b N%b vld%b",
                     name, act[12:5], act[4], act[3], act[2], act[1], act[0],
                     req[12:5], req[4], req[3], req[2], req[1], req[0]);
        end
    endtask

    function automatic logic [12:0] dut_vec();
        return {bus.output_S, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n, bus.out_valid};
    endfunction

    // Model state: what the outputs must show after each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_out = '0;
            exp_vld = 1'b0;
        end else if (bus.in_valid) begin
            exp_out = ref_alu(int'(bus.input_A), int'(bus.input_B), int'(bus.op));
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) check("model", dut_vec(), {exp_out, exp_vld});
    end

    // Drive one op at the falling edge, then check DUT and model against a literal after the rise.
    task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [12:0] req);
        @(negedge clk);
        bus.input_A  = a;
        bus.input_B  = b;
        bus.op       = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(name, dut_vec(), req);
        check({name, "_ref"}, {ref_alu(int'(a), int'(b), int'(op)), 1'b1}, req);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        check_en     = 1'b0;
        reset        = 1'b1;
        bus.input_A  = '0;
        bus.input_B  = '0;
        bus.op       = '0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 13'h0);
        @(negedge clk);
        reset = 1'b0;

        apply("add_1f_5f", 8'h1F, 8'h5F, 3'b000, {8'h7E, 4'b0000, 1'b1});
`ifdef ALU_SATURATE_EN
        apply("add_80_df", 8'h80, 8'hDF, 3'b000, {8'hFF, 4'b1011, 1'b1});
`else
        apply("add_80_df", 8'h80, 8'hDF, 3'b000, {8'h5F, 4'b1010, 1'b1});
`endif
        apply("add_26_13", 8'h26, 8'h13, 3'b000, {8'h39, 4'b0000, 1'b1});
        apply("sub_26_13", 8'h26, 8'h13, 3'b001, {8'h13, 4'b0000, 1'b1});
`ifdef ALU_SATURATE_EN
        apply("sub_13_26", 8'h13, 8'h26, 3'b001, {8'h00, 4'b1100, 1'b1});
`else
        apply("sub_13_26", 8'h13, 8'h26, 3'b001, {8'hED, 4'b1001, 1'b1});
`endif
        apply("cmp_13_26", 8'h13, 8'h26, 3'b111, {8'h01, 4'b1000, 1'b1});
        apply("and_f0_3c", 8'hF0, 8'h3C, 3'b010, {8'h30, 4'b0000, 1'b1});
        apply("xor_aa_aa", 8'hAA, 8'hAA, 3'b100, {8'h00, 4'b0100, 1'b1});
        apply("shr_81_3",  8'h81, 8'h03, 3'b110, {8'h10, 4'b0000, 1'b1});
        apply("shl_81_1",  8'h81, 8'h01, 3'b101, {8'h02, 4'b1000, 1'b1});
        apply("shr_81_0",  8'h81, 8'h00, 3'b110, {8'h81, 4'b0001, 1'b1});

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.input_A  = 8'($urandom);
            bus.input_B  = 8'($urandom);
            bus.op       = 3'($urandom);
            @(posedge clk);
            #1;
            check("hold", dut_vec(), {8'h81, 4'b0001, 1'b0});
        end

        apply("pre_reset", 8'hF0, 8'h0F, 3'b011, {8'hFF, 4'b0001, 1'b1});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec(), 13'h0);
        @(negedge clk);
        reset = 1'b0;

        @(posedge clk);
        check_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.input_A  = 8'($urandom);
            bus.input_B  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            bus.op       = 3'($urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                check("rand_reset", dut_vec(), 13'h0);
                reset = 1'b0;
            end
        end
        @(negedge clk);
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
